axi4_slave_mem: RTL and testbench
=================================

Name: axi4_slave_mem

Overview:
- Synthesizable AXI4 slave memory. Directly downstream of the AXI4 bus interface; it is the DUT that the slave-side modports observe.
- Sinks the write address, write data and read address channels. Sources the write response and read data channels.
- Backs a word-addressed on-chip RAM.
- Read and write paths are independent FSMs and may be active in the same cycle.

Parameters:
- ADDR_WIDTH, 32, byte address width (from axi_parameters).
- DATA_WIDTH, 32, data bus width in bits (from axi_parameters); power of 2, 8..128.
- ID_WIDTH, 9, transaction ID width.
- MEM_DEPTH, 1024, number of DATA_WIDTH-bit words.

Ports:
- clk  in  1  clock; all logic on posedge.
- ARESET  in  1  synchronous, active-high reset.
- AWID/AWADDR/AWLEN/AWSIZE/AWBURST  in  ID_WIDTH/ADDR_WIDTH/4/3/2  write address channel.
- AWVALID in 1; AWREADY out 1.
- WID/WDATA/WSTRB/WLAST  in  ID_WIDTH/DATA_WIDTH/DATA_WIDTH/8/1  write data channel.
- WVALID in 1; WREADY out 1.
- BID/BRESP  out  ID_WIDTH/2  write response; BVALID out 1; BREADY in 1.
- ARID/ARADDR/ARLEN/ARSIZE/ARBURST  in  ID_WIDTH/ADDR_WIDTH/4/3/2  read address channel.
- ARVALID in 1; ARREADY out 1.
- RID/RDATA/RRESP/RLAST  out  ID_WIDTH/DATA_WIDTH/2/1  read data channel; RVALID out 1; RREADY in 1.

Behaviour:
- Reset: write and read FSMs go to IDLE. AWREADY=1, ARREADY=1. WREADY, BVALID, RVALID, RLAST=0. BID, BRESP, RID, RDATA, RRESP=0. Memory contents are not cleared.
- Reset asserted mid-burst aborts the burst immediately; no response is issued.
- Handshake: a transfer occurs when VALID&&READY at posedge. VALID outputs, once high, stay high with stable payload until READY.
- BEAT_BYTES = DATA_WIDTH/8. Word index = addr >> log2(BEAT_BYTES).
- Error flag is set at address acceptance when any of these hold:
  - AxSIZE != log2(BEAT_BYTES).
  - AxBURST == 2'b11.
  - WRAP with AxLEN not in {1,3,7,15}.
  - Any beat's word index >= MEM_DEPTH. This is evaluated per beat and sticky for the burst.
- Next address:
  - FIXED: unchanged.
  - INCR: addr + BEAT_BYTES.
  - WRAP: wrap_size = (LEN+1)*BEAT_BYTES, base = addr & ~(wrap_size-1), next = base | ((addr+BEAT_BYTES) & (wrap_size-1)).
  - All arithmetic is modulo 2^ADDR_WIDTH.
- Write FSM:
  - W_IDLE: AWREADY=1. On AW handshake, latch ID/addr/len/burst, clear beat count, set the error flag as above, go to W_DATA. AWREADY=0 in W_DATA.
  - W_DATA: WREADY=1. On each W handshake, write each byte lane i where WSTRB[i]=1, provided the beat is error-free; then advance the address and count.
  - Last beat is count==len. Leave W_DATA for W_RESP on that beat regardless of WLAST.
  - WLAST mismatch (WLAST=1 before the last beat, or 0 on it) sets the error flag but does not change the beat count.
  - W_RESP: BVALID=1, BID=latched AWID, BRESP = error ? 2'b10 : 2'b00. On BREADY, go to W_IDLE with AWREADY=1 the next cycle.
  - Earliest repeat: AW → W beats → B → next AW accepted; there is no address pipelining.
- Read FSM:
  - R_IDLE: ARREADY=1. On AR handshake, latch fields and go to R_DATA. RDATA is registered from mem[first word], so RVALID=1 the cycle after the AR handshake (1-cycle latency).
  - R_DATA: RID=latched ARID. RLAST=1 iff count==len. RRESP = beat error ? 2'b10 : 2'b00. RDATA=0 on an error beat.
  - On R handshake: if RLAST, go to R_IDLE. Otherwise load the next beat's RDATA/RRESP/RLAST in the same edge, giving back-to-back beats with no bubble.
  - RREADY low holds all R outputs stable.
- Read-write collision: a read beat loaded in the same cycle as a write to the same word returns the old data. A write to a word takes effect for reads loaded in any later cycle.
- Single outstanding transaction per direction. IDs are echoed and no reordering is performed.

Decomposition:
- Package axi_parameters gains:
  - burst_t enum {FIXED=2'b00, INCR=2'b01, WRAP=2'b10}.
  - resp constants RESP_OKAY=2'b00, RESP_SLVERR=2'b10.
  - wr_state_t {W_IDLE, W_DATA, W_RESP} and rd_state_t {R_IDLE, R_DATA}.
- Sub-module axi4_burst_addr_calc: combinational (addr, len, size, burst) → next_addr. It is instantiated twice, once for the write path and once for the read path.

Test Plan:
- Single write: AWADDR=0x10, LEN=0, INCR, WDATA=0xDEADBEEF, WSTRB=4'hF → BRESP=00, BID=AWID. Read of 0x10 returns 0xDEADBEEF with RLAST=1, first RVALID 1 cycle after AR.
- INCR burst: AWADDR=0x100, LEN=3, data 1,2,3,4 → each of 0x100/0x104/0x108/0x10C reads back correctly. Read burst has RLAST only on beat 4, and beats are back-to-back with RREADY=1.
- WRAP: write 0x100–0x10C with A,B,C,D, then read ARADDR=0x108, LEN=3, WRAP → RDATA sequence C,D,A,B.
- Strobe: word 0x20=0xFFFFFFFF, then write 0x00000000 with WSTRB=4'b0101 → reads 0xFF00FF00.
- Error cases:
  - AWADDR=MEM_DEPTH*4 → BRESP=10, memory unchanged.
  - ARBURST=2'b11 → all beats RRESP=10, RDATA=0.
  - AWSIZE=3'd1 on a 32-bit bus → BRESP=10.
- Backpressure/reset: hold RREADY=0 for 5 cycles mid-burst → R outputs stable. Assert ARESET during W_DATA → next cycle AWREADY=1, WREADY=0, BVALID=0; a subsequent write completes with OKAY.

Source files
------------

// File: rtl/axi4_slave_mem_pkg.sv
// Shared AXI4 types, response codes and the address-phase legality check
// used by the slave memory and its burst address calculator.
package axi_parameters;
    localparam int AXI_ADDR_WIDTH = 32;
    localparam int AXI_DATA_WIDTH = 32;

    typedef enum logic [1:0] {FIXED = 2'b00, INCR = 2'b01, WRAP = 2'b10} burst_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_t;
    typedef enum logic {R_IDLE, R_DATA} rd_state_t;

    // Burst header is illegal for a narrow/wide size, reserved burst or odd wrap length
    function automatic logic hdr_err(input logic [2:0] size, input logic [2:0] beat_size,
                                     input logic [1:0] burst, input logic [3:0] len);
        logic wrap_bad;
        wrap_bad = (burst == WRAP) &&
                   !(len == 4'd1 || len == 4'd3 || len == 4'd7 || len == 4'd15);
        return (size != beat_size) || (burst == 2'b11) || wrap_bad;
    endfunction
endpackage

// File: rtl/axi4_burst_addr_calc.sv
// Combinational next-beat address for FIXED, INCR and WRAP bursts; the
// reserved encoding falls through to INCR since such bursts are errored anyway.
module axi4_burst_addr_calc
    import axi_parameters::*;
#(
    parameter int ADDR_WIDTH = AXI_ADDR_WIDTH,
    parameter int DATA_WIDTH = AXI_DATA_WIDTH
) (
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [3:0]            len,
    input  logic [2:0]            size,
    input  logic [1:0]            burst,
    output logic [ADDR_WIDTH-1:0] next_addr
);
    localparam logic [ADDR_WIDTH-1:0] BEAT_BYTES = ADDR_WIDTH'(DATA_WIDTH / 8);

    logic [ADDR_WIDTH-1:0] incr;
    logic [ADDR_WIDTH-1:0] wrap_mask;
    logic                  unused_size;

    assign unused_size = ^size;

    always_comb begin
        incr      = addr + BEAT_BYTES;
        wrap_mask = (ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) * BEAT_BYTES - ADDR_WIDTH'(1);
        case (burst)
            FIXED:   next_addr = addr;
            WRAP:    next_addr = (addr & ~wrap_mask) | (incr & wrap_mask);
            default: next_addr = incr;
        endcase
    end
endmodule

// File: rtl/axi4_slave_mem.sv
// AXI4 slave backed by a word-addressed RAM; independent single-outstanding
// write and read FSMs, registered read data with back-to-back beats.
module axi4_slave_mem
    import axi_parameters::*;
#(
    parameter int ADDR_WIDTH = AXI_ADDR_WIDTH,
    parameter int DATA_WIDTH = AXI_DATA_WIDTH,
    parameter int ID_WIDTH   = 9,
    parameter int MEM_DEPTH  = 1024
) (
    input  logic                    clk,
    input  logic                    ARESET,
    input  logic [ID_WIDTH-1:0]     AWID,
    input  logic [ADDR_WIDTH-1:0]   AWADDR,
    input  logic [3:0]              AWLEN,
    input  logic [2:0]              AWSIZE,
    input  logic [1:0]              AWBURST,
    input  logic                    AWVALID,
    output logic                    AWREADY,
    input  logic [ID_WIDTH-1:0]     WID,
    input  logic [DATA_WIDTH-1:0]   WDATA,
    input  logic [DATA_WIDTH/8-1:0] WSTRB,
    input  logic                    WLAST,
    input  logic                    WVALID,
    output logic                    WREADY,
    output logic [ID_WIDTH-1:0]     BID,
    output logic [1:0]              BRESP,
    output logic                    BVALID,
    input  logic                    BREADY,
    input  logic [ID_WIDTH-1:0]     ARID,
    input  logic [ADDR_WIDTH-1:0]   ARADDR,
    input  logic [3:0]              ARLEN,
    input  logic [2:0]              ARSIZE,
    input  logic [1:0]              ARBURST,
    input  logic                    ARVALID,
    output logic                    ARREADY,
    output logic [ID_WIDTH-1:0]     RID,
    output logic [DATA_WIDTH-1:0]   RDATA,
    output logic [1:0]              RRESP,
    output logic                    RLAST,
    output logic                    RVALID,
    input  logic                    RREADY
);
    localparam int         BEAT_BYTES = DATA_WIDTH / 8;
    localparam int         OFF_W      = $clog2(BEAT_BYTES);
    localparam int         IDX_W      = $clog2(MEM_DEPTH);
    localparam logic [2:0] BEAT_SIZE  = 3'(OFF_W);

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];
    logic                  unused_wid;
    assign unused_wid = ^WID;

    function automatic logic oob(input logic [ADDR_WIDTH-1:0] a);
        return (a >> OFF_W) >= ADDR_WIDTH'(MEM_DEPTH);
    endfunction

    function automatic logic [IDX_W-1:0] widx(input logic [ADDR_WIDTH-1:0] a);
        return IDX_W'(a >> OFF_W);
    endfunction

    wr_state_t             wr_state_q, wr_state_d;
    logic [ID_WIDTH-1:0]   awid_q, awid_d;
    logic [ADDR_WIDTH-1:0] waddr_q, waddr_d, waddr_next;
    logic [3:0]            wlen_q, wlen_d, wcnt_q, wcnt_d;
    logic [1:0]            wburst_q, wburst_d;
    logic                  werr_q, werr_d, wr_fire;

    rd_state_t             rd_state_q, rd_state_d;
    logic [ID_WIDTH-1:0]   rid_q, rid_d;
    logic [ADDR_WIDTH-1:0] raddr_q, raddr_d, raddr_next;
    logic [3:0]            rlen_q, rlen_d, rcnt_q, rcnt_d;
    logic [1:0]            rburst_q, rburst_d, rresp_q, rresp_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  rerr_q, rerr_d, rlast_q, rlast_d, rvalid_q, rvalid_d;

    axi4_burst_addr_calc #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_wr_calc (
        .addr(waddr_q), .len(wlen_q), .size(BEAT_SIZE), .burst(wburst_q), .next_addr(waddr_next)
    );
    axi4_burst_addr_calc #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_rd_calc (
        .addr(raddr_q), .len(rlen_q), .size(BEAT_SIZE), .burst(rburst_q), .next_addr(raddr_next)
    );

    // werr_q always covers the current beat's address, so it alone gates the RAM write
    always_comb begin
        wr_state_d = wr_state_q;
        awid_d     = awid_q;
        waddr_d    = waddr_q;
        wlen_d     = wlen_q;
        wburst_d   = wburst_q;
        wcnt_d     = wcnt_q;
        werr_d     = werr_q;
        wr_fire    = 1'b0;
        case (wr_state_q)
            W_IDLE: if (AWVALID) begin
                awid_d     = AWID;
                waddr_d    = AWADDR;
                wlen_d     = AWLEN;
                wburst_d   = AWBURST;
                wcnt_d     = '0;
                werr_d     = hdr_err(AWSIZE, BEAT_SIZE, AWBURST, AWLEN) || oob(AWADDR);
                wr_state_d = W_DATA;
            end
            W_DATA: if (WVALID) begin
                wr_fire = !werr_q;
                if (wcnt_q == wlen_q) begin
                    werr_d     = werr_q || !WLAST;
                    wr_state_d = W_RESP;
                end else begin
                    waddr_d = waddr_next;
                    wcnt_d  = wcnt_q + 4'd1;
                    werr_d  = werr_q || WLAST || oob(waddr_next);
                end
            end
            W_RESP: if (BREADY) wr_state_d = W_IDLE;
            default: wr_state_d = W_IDLE;
        endcase
    end

    assign AWREADY = (wr_state_q == W_IDLE);
    assign WREADY  = (wr_state_q == W_DATA);
    assign BVALID  = (wr_state_q == W_RESP);
    assign BID     = awid_q;
    assign BRESP   = (BVALID && werr_q) ? RESP_SLVERR : RESP_OKAY;

    // RAM is read combinationally and captured into rdata_q, so a same-edge write is not seen
    always_comb begin
        logic beat_err;
        rd_state_d = rd_state_q;
        rid_d      = rid_q;
        raddr_d    = raddr_q;
        rlen_d     = rlen_q;
        rburst_d   = rburst_q;
        rcnt_d     = rcnt_q;
        rerr_d     = rerr_q;
        rdata_d    = rdata_q;
        rresp_d    = rresp_q;
        rlast_d    = rlast_q;
        rvalid_d   = rvalid_q;
        beat_err   = 1'b0;
        case (rd_state_q)
            R_IDLE: if (ARVALID) begin
                beat_err   = hdr_err(ARSIZE, BEAT_SIZE, ARBURST, ARLEN) || oob(ARADDR);
                rid_d      = ARID;
                raddr_d    = ARADDR;
                rlen_d     = ARLEN;
                rburst_d   = ARBURST;
                rcnt_d     = '0;
                rerr_d     = beat_err;
                rdata_d    = beat_err ? '0 : mem[widx(ARADDR)];
                rresp_d    = beat_err ? RESP_SLVERR : RESP_OKAY;
                rlast_d    = (ARLEN == 4'd0);
                rvalid_d   = 1'b1;
                rd_state_d = R_DATA;
            end
            R_DATA: if (RREADY) begin
                if (rlast_q) begin
                    rvalid_d   = 1'b0;
                    rlast_d    = 1'b0;
                    rd_state_d = R_IDLE;
                end else begin
                    beat_err = rerr_q || oob(raddr_next);
                    raddr_d  = raddr_next;
                    rcnt_d   = rcnt_q + 4'd1;
                    rerr_d   = beat_err;
                    rdata_d  = beat_err ? '0 : mem[widx(raddr_next)];
                    rresp_d  = beat_err ? RESP_SLVERR : RESP_OKAY;
                    rlast_d  = ((rcnt_q + 4'd1) == rlen_q);
                end
            end
            default: rd_state_d = R_IDLE;
        endcase
    end

    assign ARREADY = (rd_state_q == R_IDLE);
    assign RID     = rid_q;
    assign RDATA   = rdata_q;
    assign RRESP   = rresp_q;
    assign RLAST   = rlast_q;
    assign RVALID  = rvalid_q;

    always_ff @(posedge clk) begin
        if (ARESET) begin
            wr_state_q <= W_IDLE;
            awid_q     <= '0;
            waddr_q    <= '0;
            wlen_q     <= '0;
            wburst_q   <= '0;
            wcnt_q     <= '0;
            werr_q     <= 1'b0;
            rd_state_q <= R_IDLE;
            rid_q      <= '0;
            raddr_q    <= '0;
            rlen_q     <= '0;
            rburst_q   <= '0;
            rcnt_q     <= '0;
            rerr_q     <= 1'b0;
            rdata_q    <= '0;
            rresp_q    <= '0;
            rlast_q    <= 1'b0;
            rvalid_q   <= 1'b0;
        end else begin
            wr_state_q <= wr_state_d;
            awid_q     <= awid_d;
            waddr_q    <= waddr_d;
            wlen_q     <= wlen_d;
            wburst_q   <= wburst_d;
            wcnt_q     <= wcnt_d;
            werr_q     <= werr_d;
            rd_state_q <= rd_state_d;
            rid_q      <= rid_d;
            raddr_q    <= raddr_d;
            rlen_q     <= rlen_d;
            rburst_q   <= rburst_d;
            rcnt_q     <= rcnt_d;
            rerr_q     <= rerr_d;
            rdata_q    <= rdata_d;
            rresp_q    <= rresp_d;
            rlast_q    <= rlast_d;
            rvalid_q   <= rvalid_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_fire) begin
            for (int i = 0; i < BEAT_BYTES; i++) begin
                if (WSTRB[i]) mem[widx(waddr_q)][8*i +: 8] <= WDATA[8*i +: 8];
            end
        end
    end
endmodule

// File: tb/tb_axi4_slave_mem.sv
// Scoreboard bench for axi4_slave_mem: a word-array reference model predicts
// every B and R response; negedge monitors pop and compare on each handshake.
module tb_axi4_slave_mem;
    import axi_parameters::*;
    localparam int MD = 1024;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        ARESET;
    logic [8:0]  AWID, WID, BID, ARID, RID;
    logic [31:0] AWADDR, ARADDR, WDATA, RDATA;
    logic [3:0]  AWLEN, ARLEN, WSTRB;
    logic [2:0]  AWSIZE, ARSIZE;
    logic [1:0]  AWBURST, ARBURST, BRESP, RRESP;
    logic        AWVALID, AWREADY, WLAST, WVALID, WREADY, BVALID, BREADY;
    logic        ARVALID, ARREADY, RLAST, RVALID, RREADY;

    axi4_slave_mem #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(9), .MEM_DEPTH(MD)) dut (
        .clk(clk), .ARESET(ARESET),
        .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
        .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WID(WID), .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
        .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
        .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
    );

    typedef struct { logic [8:0] id; logic [1:0] resp; } b_exp_t;
    typedef struct { logic [8:0] id; logic [31:0] data; logic [1:0] resp; logic last; bit known; } r_exp_t;

    b_exp_t      bq[$];
    r_exp_t      rq[$];
    logic [31:0] mdl [MD];
    bit          known [MD];
    int          checks = 0, passes = 0, cyc = 0;
    int          beat_cyc[$];
    bit          force_rr = 1'b0;
    logic        rr_val = 1'b1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic timeout(input string name);
        checks++;
        $display("FAIL %s: got no DUT response expected one within the cycle budget", name);
    endtask

    // Reference rules written directly from the AXI burst definitions
    function automatic bit m_oob(input logic [31:0] a);
        return (a >> 2) >= 32'(MD);
    endfunction

    function automatic bit m_hdr(input logic [2:0] size, input logic [1:0] burst, input logic [3:0] len);
        return (size != 3'd2) || (burst == 2'b11) ||
               (burst == 2'b10 && !(len == 1 || len == 3 || len == 7 || len == 15));
    endfunction

    function automatic logic [31:0] m_next(input logic [31:0] a, input logic [3:0] len, input logic [1:0] burst);
        logic [31:0] ws, b;
        if (burst == 2'b00) return a;
        if (burst == 2'b10) begin
            ws = (32'(len) + 32'd1) * 32'd4;
            b  = a - (a % ws);
            return b + ((a - b + 32'd4) % ws);
        end
        return a + 32'd4;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_hs(input int ch, input string name);
        int  n = 0;
        bit  rdy;
        forever begin
            @(negedge clk);
            case (ch)
                0:       rdy = AWREADY;
                1:       rdy = WREADY;
                default: rdy = ARREADY;
            endcase
            if (rdy) break;
            n++;
            if (n > 300) begin timeout(name); break; end
        end
        tick();
    endtask

    task automatic wait_drain(input bit rd, input string name);
        int n = 0;
        while ((rd ? rq.size() : bq.size()) != 0) begin
            tick();
            n++;
            if (n > 600) begin
                timeout(name);
                if (rd) rq.delete(); else bq.delete();
                break;
            end
        end
    endtask

    task automatic do_write(input logic [8:0] id, input logic [31:0] addr, input logic [3:0] len,
                            input logic [2:0] size, input logic [1:0] burst,
                            input logic [31:0] d [16], input logic [3:0] s [16], input int bad);
        bit          err;
        logic [31:0] a;
        logic        wl [16];
        int          idx;
        err = m_hdr(size, burst, len);
        a   = addr;
        for (int k = 0; k <= int'(len); k++) begin
            err = err | m_oob(a);
            wl[k] = (k == int'(len)) ^ (k == bad);
            if (!err) begin
                idx = int'(a >> 2);
                for (int i = 0; i < 4; i++) if (s[k][i]) mdl[idx][8*i +: 8] = d[k][8*i +: 8];
                if (s[k] == 4'hF) known[idx] = 1'b1;
            end
            if (wl[k] != (k == int'(len))) err = 1'b1;
            a = m_next(a, len, burst);
        end
        bq.push_back('{id: id, resp: err ? 2'b10 : 2'b00});
        AWID = id; AWADDR = addr; AWLEN = len; AWSIZE = size; AWBURST = burst; AWVALID = 1'b1;
        wait_hs(0, "aw_handshake");
        AWVALID = 1'b0;
        for (int k = 0; k <= int'(len); k++) begin
            repeat ($urandom_range(0, 1)) tick();
            WID = id; WDATA = d[k]; WSTRB = s[k]; WLAST = wl[k]; WVALID = 1'b1;
            wait_hs(1, "w_handshake");
            WVALID = 1'b0;
        end
        wait_drain(1'b0, "b_response");
    endtask

    task automatic do_read(input logic [8:0] id, input logic [31:0] addr, input logic [3:0] len,
                           input logic [2:0] size, input logic [1:0] burst, output int ar_cyc);
        bit          err;
        logic [31:0] a;
        r_exp_t      e;
        err = m_hdr(size, burst, len);
        a   = addr;
        for (int k = 0; k <= int'(len); k++) begin
            err    = err | m_oob(a);
            e.id   = id;
            e.resp = err ? 2'b10 : 2'b00;
            e.last = (k == int'(len));
            if (err) begin e.data = 32'h0; e.known = 1'b1; end
            else begin e.data = mdl[int'(a >> 2)]; e.known = known[int'(a >> 2)]; end
            rq.push_back(e);
            a = m_next(a, len, burst);
        end
        ARID = id; ARADDR = addr; ARLEN = len; ARSIZE = size; ARBURST = burst; ARVALID = 1'b1;
        wait_hs(2, "ar_handshake");
        ar_cyc  = cyc;
        ARVALID = 1'b0;
        wait_drain(1'b1, "r_beats");
    endtask

    initial begin
        RREADY = 1'b0;
        BREADY = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            RREADY = force_rr ? rr_val : ($urandom_range(0, 3) != 0);
            BREADY = ($urandom_range(0, 2) != 0);
        end
    end

    logic        r_stall_prev = 1'b0;
    logic [63:0] r_prev;
    always @(negedge clk) begin
        b_exp_t be;
        r_exp_t re;
        if (BVALID && BREADY) begin
            if (bq.size() == 0) begin
                checks++;
                $display("FAIL b_unexpected: got BID=%0h expected no response", BID);
            end else begin
                be = bq.pop_front();
                chk("bid", 64'(BID), 64'(be.id));
                chk("bresp", 64'(BRESP), 64'(be.resp));
            end
        end
        if (RVALID && RREADY) begin
            beat_cyc.push_back(cyc + 1);
            if (rq.size() == 0) begin
                checks++;
                $display("FAIL r_unexpected: got RID=%0h expected no beat", RID);
            end else begin
                re = rq.pop_front();
                chk("rid", 64'(RID), 64'(re.id));
                chk("rresp", 64'(RRESP), 64'(re.resp));
                chk("rlast", 64'(RLAST), 64'(re.last));
                if (re.known) chk("rdata", 64'(RDATA), 64'(re.data));
            end
        end
        if (r_stall_prev && !ARESET) begin
            chk("r_hold_valid", 64'(RVALID), 64'd1);
            chk("r_hold_payload", 64'({RID, RDATA, RRESP, RLAST}), r_prev);
        end
        r_stall_prev = RVALID && !RREADY && !ARESET;
        r_prev       = 64'({RID, RDATA, RRESP, RLAST});
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got simulation still running expected finish");
        $fatal(1);
    end

    logic [31:0] d [16];
    logic [3:0]  s [16];
    int          arc;
    logic [3:0]  len;
    logic [1:0]  bu;
    logic [2:0]  sz;
    logic [31:0] addr;
    int          sel;

    initial begin
        ARESET = 1'b1;
        AWID = '0; AWADDR = '0; AWLEN = '0; AWSIZE = 3'd2; AWBURST = 2'b01; AWVALID = 1'b0;
        WID = '0; WDATA = '0; WSTRB = '0; WLAST = 1'b0; WVALID = 1'b0;
        ARID = '0; ARADDR = '0; ARLEN = '0; ARSIZE = 3'd2; ARBURST = 2'b01; ARVALID = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        chk("rst_awready", 64'(AWREADY), 64'd1);
        chk("rst_arready", 64'(ARREADY), 64'd1);
        chk("rst_wready", 64'(WREADY), 64'd0);
        chk("rst_bvalid", 64'(BVALID), 64'd0);
        chk("rst_rvalid", 64'(RVALID), 64'd0);
        chk("rst_rlast", 64'(RLAST), 64'd0);
        chk("rst_bid_bresp", 64'({BID, BRESP}), 64'd0);
        chk("rst_rid_rdata_rresp", 64'({RID, RDATA, RRESP}), 64'd0);
        tick();
        ARESET = 1'b0;

        // Fill words 0..127 so later reads have known contents
        for (int b = 0; b < 8; b++) begin
            for (int k = 0; k < 16; k++) begin d[k] = $urandom; s[k] = 4'hF; end
            do_write(9'(b), 32'(b * 64), 4'd15, 3'd2, 2'b01, d, s, -1);
        end

        force_rr = 1'b1; rr_val = 1'b1;
        d[0] = 32'hDEADBEEF; s[0] = 4'hF;
        do_write(9'h5A, 32'h10, 4'd0, 3'd2, 2'b01, d, s, -1);
        beat_cyc.delete();
        do_read(9'h1C3, 32'h10, 4'd0, 3'd2, 2'b01, arc);
        if (beat_cyc.size() > 0) chk("rd_latency", 64'(beat_cyc[0]), 64'(arc + 1));
        else timeout("rd_latency");

        for (int k = 0; k < 4; k++) begin d[k] = 32'(k + 1); s[k] = 4'hF; end
        do_write(9'h11, 32'h100, 4'd3, 3'd2, 2'b01, d, s, -1);
        beat_cyc.delete();
        do_read(9'h12, 32'h100, 4'd3, 3'd2, 2'b01, arc);
        if (beat_cyc.size() == 4) begin
            chk("incr_first_beat", 64'(beat_cyc[0]), 64'(arc + 1));
            chk("incr_back_to_back", 64'(beat_cyc[3]), 64'(arc + 4));
        end else timeout("incr_beats");

        d[0] = 32'hA; d[1] = 32'hB; d[2] = 32'hC; d[3] = 32'hD;
        do_write(9'h21, 32'h100, 4'd3, 3'd2, 2'b01, d, s, -1);
        do_read(9'h22, 32'h108, 4'd3, 3'd2, 2'b10, arc);

        d[0] = 32'hFFFFFFFF; s[0] = 4'hF;
        do_write(9'h31, 32'h20, 4'd0, 3'd2, 2'b01, d, s, -1);
        d[0] = 32'h0; s[0] = 4'b0101;
        do_write(9'h32, 32'h20, 4'd0, 3'd2, 2'b01, d, s, -1);
        do_read(9'h33, 32'h20, 4'd0, 3'd2, 2'b01, arc);

        for (int k = 0; k < 16; k++) begin d[k] = $urandom; s[k] = 4'hF; end
        do_write(9'h41, 32'(MD * 4), 4'd0, 3'd2, 2'b01, d, s, -1);
        do_write(9'h42, 32'((MD - 2) * 4), 4'd3, 3'd2, 2'b01, d, s, -1);
        do_read(9'h43, 32'((MD - 2) * 4), 4'd3, 3'd2, 2'b01, arc);
        do_read(9'h44, 32'h40, 4'd3, 3'd2, 2'b11, arc);
        do_write(9'h45, 32'h30, 4'd0, 3'd1, 2'b01, d, s, -1);
        do_read(9'h46, 32'h30, 4'd0, 3'd2, 2'b01, arc);
        do_read(9'h47, 32'h40, 4'd2, 3'd2, 2'b10, arc);
        do_write(9'h48, 32'h60, 4'd3, 3'd2, 2'b01, d, s, 1);
        do_write(9'h49, 32'h70, 4'd1, 3'd2, 2'b01, d, s, 1);
        do_read(9'h4A, 32'h60, 4'd3, 3'd2, 2'b01, arc);

        fork
            do_read(9'h51, 32'h80, 4'd7, 3'd2, 2'b01, arc);
            begin
                repeat (3) tick();
                rr_val = 1'b0;
                repeat (5) tick();
                rr_val = 1'b1;
            end
        join

        AWID = 9'h61; AWADDR = 32'h40; AWLEN = 4'd3; AWSIZE = 3'd2; AWBURST = 2'b01; AWVALID = 1'b1;
        wait_hs(0, "rst_aw_handshake");
        AWVALID = 1'b0;
        WDATA = 32'h12345678; WSTRB = 4'h0; WLAST = 1'b0; WVALID = 1'b1;
        wait_hs(1, "rst_w_handshake");
        WVALID = 1'b0;
        ARESET = 1'b1;
        tick();
        @(negedge clk);
        chk("midrst_awready", 64'(AWREADY), 64'd1);
        chk("midrst_wready", 64'(WREADY), 64'd0);
        chk("midrst_bvalid", 64'(BVALID), 64'd0);
        tick();
        ARESET = 1'b0;
        for (int k = 0; k < 4; k++) begin d[k] = $urandom; s[k] = 4'hF; end
        do_write(9'h62, 32'h40, 4'd3, 3'd2, 2'b01, d, s, -1);
        do_read(9'h63, 32'h40, 4'd3, 3'd2, 2'b01, arc);

        force_rr = 1'b0;
        for (int t = 0; t < 80; t++) begin
            sel  = int'($urandom_range(0, 9));
            bu   = (sel < 2) ? 2'b00 : (sel < 7) ? 2'b01 : (sel < 9) ? 2'b10 : 2'b11;
            len  = 4'($urandom_range(0, 15));
            if (bu == 2'b10 && $urandom_range(0, 4) != 0) len = 4'((2 << $urandom_range(0, 3)) - 1);
            sz   = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 7)) : 3'd2;
            addr = ($urandom_range(0, 7) == 0) ? 32'($urandom_range(MD - 6, MD + 2) * 4)
                                               : 32'($urandom_range(0, 127) * 4);
            if ($urandom_range(0, 1) == 0) begin
                for (int k = 0; k < 16; k++) begin d[k] = $urandom; s[k] = 4'($urandom); end
                do_write(9'($urandom), addr, len, sz, bu, d, s,
                         ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, int'(len))) : -1);
            end else begin
                do_read(9'($urandom), addr, len, sz, bu, arc);
            end
        end

        repeat (4) tick();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
